// File: rtl/binary_dilation_3x3.sv
// Streaming 3x3 binary dilation over a raster pixel stream, with end-of-frame flush,
// input backpressure and a frame_done pulse on the last output pixel.
module binary_dilation_3x3 #(
   parameter int IMAGE_WIDTH      = 320,
   parameter int IMAGE_HEIGHT     = 464,
   parameter int DATA_WIDTH       = 8,
   parameter bit BACKGROUND_COLOR = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pixel_valid,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   output logic                  in_ready,
   output logic                  pixel_out_valid,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  frame_done
);

   localparam int TOTAL      = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int LAST_BEAT_I = TOTAL + IMAGE_WIDTH;
   localparam int NW         = $clog2(LAST_BEAT_I + 1);
   localparam int CW         = $clog2(IMAGE_WIDTH);
   localparam int RW         = $clog2(IMAGE_HEIGHT);

   localparam logic [NW-1:0] LAST_IN   = NW'(TOTAL - 1);
   localparam logic [NW-1:0] LAST_BEAT = NW'(LAST_BEAT_I);
   localparam logic [NW-1:0] FIRST_OUT = NW'(IMAGE_WIDTH + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);

   localparam logic [DATA_WIDTH-1:0] BG_VAL = {DATA_WIDTH{BACKGROUND_COLOR}};
   localparam logic [DATA_WIDTH-1:0] FG_VAL = {DATA_WIDTH{~BACKGROUND_COLOR}};

   typedef enum logic {STREAM, FLUSH} state_t;

   state_t                 state, next_state;
   logic                   beat, new_bit;
   logic [NW-1:0]          beat_count;
   logic [CW-1:0]          col;
   logic [CW-1:0]          center_col;
   logic [RW-1:0]          center_row;
   logic [IMAGE_WIDTH-1:0] line1, line2;
   logic [2:0]             win_top, win_mid, win_bot;
   logic                   s1_valid, s1_left, s1_right, s1_top, s1_bottom, s1_last;
   logic [2:0]             col_mask;
   logic                   hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= STREAM;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         STREAM: if (pixel_valid && beat_count == LAST_IN) next_state = FLUSH;
         FLUSH:  if (beat_count == LAST_BEAT) next_state = STREAM;
         default: next_state = STREAM;
      endcase
   end

   // Flush beats inject background so the last row still sees its lower neighbours.
   always_comb begin
      in_ready = (state == STREAM);
      beat     = (state == STREAM) ? pixel_valid : 1'b1;
      new_bit  = (state == STREAM) && (pixel_in[DATA_WIDTH-1] != BACKGROUND_COLOR);
   end

   // Window's right column is the newest beat; the center sits W+1 beats behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_count <= '0;
         col        <= '0;
         center_col <= '0;
         center_row <= '0;
         line1      <= '0;
         line2      <= '0;
         win_top    <= '0;
         win_mid    <= '0;
         win_bot    <= '0;
         s1_valid   <= 1'b0;
         s1_left    <= 1'b0;
         s1_right   <= 1'b0;
         s1_top     <= 1'b0;
         s1_bottom  <= 1'b0;
         s1_last    <= 1'b0;
      end else begin
         s1_valid <= 1'b0;
         if (beat) begin
            if (beat_count == LAST_BEAT) begin
               beat_count <= '0;
               col        <= '0;
            end else begin
               beat_count <= beat_count + 1'b1;
               col        <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
            line2[col] <= line1[col];
            line1[col] <= new_bit;
            win_top    <= {line2[col], win_top[2:1]};
            win_mid    <= {line1[col], win_mid[2:1]};
            win_bot    <= {new_bit, win_bot[2:1]};
            if (beat_count >= FIRST_OUT) begin
               s1_valid  <= 1'b1;
               s1_left   <= (center_col == '0);
               s1_right  <= (center_col == COL_LAST);
               s1_top    <= (center_row == '0);
               s1_bottom <= (center_row == ROW_LAST);
               s1_last   <= (beat_count == LAST_BEAT);
               if (center_col == COL_LAST) begin
                  center_col <= '0;
                  center_row <= (center_row == ROW_LAST) ? '0 : center_row + 1'b1;
               end else begin
                  center_col <= center_col + 1'b1;
               end
            end
         end
      end
   end

   // Neighbours outside the frame are masked, which also prevents row wrap-around.
   always_comb begin
      col_mask = {~s1_right, 1'b1, ~s1_left};
      hit = (|(win_top & col_mask & {3{~s1_top}})) |
            (|(win_mid & col_mask)) |
            (|(win_bot & col_mask & {3{~s1_bottom}}));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_out_valid <= 1'b0;
         pixel_out       <= BG_VAL;
         frame_done      <= 1'b0;
      end else begin
         pixel_out_valid <= s1_valid;
         pixel_out       <= (s1_valid && hit) ? FG_VAL : BG_VAL;
         frame_done      <= s1_valid && s1_last;
      end
   end

endmodule

// File: tb/tb_binary_dilation_3x3.sv
// Directed bench for binary_dilation_3x3 on a 5x4 frame, both background polarities.
module tb_binary_dilation_3x3;

   localparam int W = 5;
   localparam int H = 4;
   localparam int N = W * H;

   typedef bit img_t [N];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pixel_valid = 1'b0;
   logic [7:0] pixel_in = 8'd0;
   logic       in_ready, pixel_out_valid, frame_done;
   logic [7:0] pixel_out;
   logic       b_pixel_valid = 1'b0;
   logic [7:0] b_pixel_in = 8'd0;
   logic       b_in_ready, b_pixel_out_valid, b_frame_done;
   logic [7:0] b_pixel_out;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int ready_low = 0;
   int acc_cyc [N];

   logic [7:0] out_q [$];
   int         out_cyc [$];
   logic       done_q [$];
   logic [7:0] b_out_q [$];
   logic       b_done_q [$];

   img_t img_a, img_b, img_c;

   always #5 clk = ~clk;

   binary_dilation_3x3 #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8), .BACKGROUND_COLOR(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
      .in_ready(in_ready), .pixel_out_valid(pixel_out_valid), .pixel_out(pixel_out), .frame_done(frame_done));

   binary_dilation_3x3 #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8), .BACKGROUND_COLOR(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .pixel_valid(b_pixel_valid), .pixel_in(b_pixel_in),
      .in_ready(b_in_ready), .pixel_out_valid(b_pixel_out_valid), .pixel_out(b_pixel_out), .frame_done(b_frame_done));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pixel_out_valid) begin
         out_q.push_back(pixel_out);
         out_cyc.push_back(cyc);
         done_q.push_back(frame_done);
      end else begin
         check("idle_bg", {24'd0, pixel_out}, 32'd255);
         check("idle_done", {31'd0, frame_done}, 32'd0);
      end
      if (!in_ready) ready_low++;
      if (b_pixel_out_valid) begin
         b_out_q.push_back(b_pixel_out);
         b_done_q.push_back(b_frame_done);
      end
   end

   function automatic logic [7:0] golden(input img_t im, input int k);
      int  r = k / W;
      int  c = k % W;
      bit  any = 1'b0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
               if (im[(r + dr) * W + c + dc]) any = 1'b1;
      return any ? 8'd0 : 8'd255;
   endfunction

   // Foreground pixels use 100 (MSB 0), background 200 (MSB 1) to exercise MSB classification.
   task automatic send_frame(input img_t im, input int n_pix, input bit gaps, input bit hold);
      int  waited;
      int  gap_n;
      logic rdy;
      int  t;
      for (int i = 0; i < n_pix; i++) begin
         gap_n = 0;
         while (gaps && $urandom_range(0, 1) == 1 && gap_n < 4) begin
            pixel_valid = 1'b0;
            @(posedge clk); #1;
            gap_n++;
         end
         pixel_valid = 1'b1;
         pixel_in = im[i] ? 8'd100 : 8'd200;
         waited = 0;
         forever begin
            rdy = in_ready;
            t = cyc;
            @(posedge clk); #1;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
               check("accept_timeout", 32'd0, 32'd1);
               break;
            end
         end
         acc_cyc[i] = t;
      end
      if (hold) begin
         pixel_in = 8'd100;
         waited = 0;
         while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
         end
         check("hold_release", {31'd0, in_ready}, 32'd1);
      end
      pixel_valid = 1'b0;
   endtask

   task automatic wait_outputs(input int count);
      int waited = 0;
      while (out_q.size() < count && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      check("output_count", out_q.size(), count);
   endtask

   task automatic check_output(input img_t im, input int base);
      for (int i = 0; i < N; i++) begin
         if (base + i < out_q.size()) begin
            check($sformatf("pix%0d", i), {24'd0, out_q[base + i]}, {24'd0, golden(im, i)});
            check($sformatf("done%0d", i), {31'd0, done_q[base + i]}, (i == N - 1) ? 32'd1 : 32'd0);
         end
      end
   endtask

   task automatic clear_queues();
      out_q.delete();
      out_cyc.delete();
      done_q.delete();
   endtask

   initial begin
      int zeros;
      int waited;
      for (int i = 0; i < N; i++) begin
         img_a[i] = 1'b0;
         img_b[i] = 1'b0;
         img_c[i] = 1'b0;
      end
      img_a[1 * W + 2] = 1'b1;
      img_b[0] = 1'b1;
      img_c[3] = 1'b1;
      img_c[2 * W + 4] = 1'b1;
      img_c[3 * W + 0] = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_valid", {31'd0, pixel_out_valid}, 32'd0);
      check("rst_out", {24'd0, pixel_out}, 32'd255);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single foreground at (1,2), continuous stream, with timing checks.
      ready_low = 0;
      send_frame(img_a, N, 1'b0, 1'b0);
      check("ready_drop", {31'd0, in_ready}, 32'd0);
      wait_outputs(N);
      check_output(img_a, 0);
      zeros = 0;
      foreach (out_q[i]) if (out_q[i] == 8'd0) zeros++;
      check("fg_count", zeros, 32'd9);
      if (out_q.size() >= N) begin
         check("first_out_cycle", out_cyc[0], acc_cyc[W + 1] + 2);
         check("last_out_cycle", out_cyc[N - 1], acc_cyc[N - 1] + W + 3);
      end
      check("ready_low_cycles", ready_low, W + 1);
      clear_queues();

      // Corner foreground: no wrap onto row ends.
      send_frame(img_b, N, 1'b0, 1'b0);
      wait_outputs(N);
      check_output(img_b, 0);
      if (out_q.size() >= N) begin
         check("corner_11", {24'd0, out_q[W + 1]}, 32'd0);
         check("row0_end", {24'd0, out_q[W - 1]}, 32'd255);
         check("last_px", {24'd0, out_q[N - 1]}, 32'd255);
      end
      clear_queues();

      // Two back-to-back frames with random gaps.
      send_frame(img_a, N, 1'b1, 1'b0);
      send_frame(img_c, N, 1'b1, 1'b0);
      wait_outputs(2 * N);
      check_output(img_a, 0);
      check_output(img_c, N);
      repeat (20) @(posedge clk);
      #1;
      check("no_extra_out", out_q.size(), 2 * N);
      clear_queues();

      // Valid held through flush must not leak into the next frame.
      send_frame(img_c, N, 1'b0, 1'b1);
      wait_outputs(N);
      check_output(img_c, 0);
      clear_queues();
      send_frame(img_a, N, 1'b0, 1'b0);
      wait_outputs(N);
      check_output(img_a, 0);
      clear_queues();

      // Reset at input index 9, then a fresh frame.
      send_frame(img_c, 9, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_valid", {31'd0, pixel_out_valid}, 32'd0);
      check("midrst_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      clear_queues();
      @(posedge clk); #1;
      send_frame(img_b, N, 1'b0, 1'b0);
      wait_outputs(N);
      check_output(img_b, 0);
      clear_queues();

      // Inverse polarity: 128 is foreground at (2,2), 127 is background.
      for (int i = 0; i < N; i++) begin
         b_pixel_valid = 1'b1;
         b_pixel_in = (i == 2 * W + 2) ? 8'd128 : 8'd127;
         @(posedge clk); #1;
      end
      b_pixel_valid = 1'b0;
      waited = 0;
      while (b_out_q.size() < N && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      check("b_count", b_out_q.size(), N);
      for (int i = 0; i < N; i++) begin
         if (i < b_out_q.size()) begin
            check($sformatf("b_pix%0d", i), {24'd0, b_out_q[i]},
                  ((i / W) >= 1 && (i / W) <= 3 && (i % W) >= 1 && (i % W) <= 3) ? 32'd255 : 32'd0);
            check($sformatf("b_done%0d", i), {31'd0, b_done_q[i]}, (i == N - 1) ? 32'd1 : 32'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
